// File: rtl/skeleton_ram_burst_if.sv
// Bus bundle between the device data bus and the burst RAM skeleton.
// The master side drives commands and write data; the slave side returns
// read data, status and the constant metadata header.
interface skeleton_ram_burst_if #(
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_ADR  = 6,
  parameter int BITWIDTH_LEN  = 6,
  parameter int BITWIDTH_HEAD = 30
) ();

  logic                     en;
  logic                     trgg_start_calc;
  logic                     rnw;
  logic [BITWIDTH_ADR-1:0]  adr;
  logic [BITWIDTH_LEN-1:0]  len;
  logic [BITWIDTH_SYS-1:0]  data_in;
  logic                     din_valid;
  logic [BITWIDTH_SYS-1:0]  data_out;
  logic                     dout_valid;
  logic [BITWIDTH_HEAD-1:0] data_head;
  logic                     rdy;
  logic                     done;

  modport master (
    output en, trgg_start_calc, rnw, adr, len, data_in, din_valid,
    input  data_out, dout_valid, data_head, rdy, done
  );

  modport slave (
    input  en, trgg_start_calc, rnw, adr, len, data_in, din_valid,
    output data_out, dout_valid, data_head, rdy, done
  );

endinterface

// File: rtl/skeleton_ram_burst.sv
// Burst RAM test skeleton: length-programmable write/read bursts with
// auto-incrementing, wrapping addresses into a single-port synchronous RAM,
// plus a configurable read pipeline. EN low freezes every piece of state.
module skeleton_ram_burst #(
  parameter int BITWIDTH_IN   = 12,
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_ADR  = 6,
  parameter int BITWIDTH_LEN  = 6,
  parameter int RD_LATENCY    = 1,
  parameter int BITWIDTH_HEAD = 30
) (
  input logic                clk_sys,
  input logic                rstn,
  skeleton_ram_burst_if.slave bus
);

  localparam int DEPTH = 2 ** BITWIDTH_ADR;
  localparam int CW    = BITWIDTH_LEN + 1;

  // A zero length field means a full 2**BITWIDTH_LEN burst, hence one extra counter bit.
  localparam logic [CW-1:0] FULL_LEN = CW'(2 ** BITWIDTH_LEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [3:0] HEAD_LAT = 4'(RD_LATENCY);
  localparam logic [5:0] HEAD_LEN = 6'(BITWIDTH_LEN);
  localparam logic [5:0] HEAD_ADR = 6'(BITWIDTH_ADR);
  localparam logic [4:0] HEAD_IN  = 5'(BITWIDTH_IN);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [BITWIDTH_ADR-1:0] ptr;
  logic [CW-1:0]           cnt;
  logic [BITWIDTH_IN-1:0]  mem [DEPTH];
  logic [RD_LATENCY-1:0]   pipe_valid;
  logic [BITWIDTH_IN-1:0]  pipe_data [RD_LATENCY];
  logic                    out_valid;
  logic [BITWIDTH_IN-1:0]  out_data;
  logic                    done_q;
  logic                    load;
  logic                    wr_en;
  logic                    rd_issue;
  logic                    finish;
  logic [BITWIDTH_IN-1:0]  payload;
  logic                    unused_low_bits;

  assign payload         = bus.data_in[BITWIDTH_SYS-1 -: BITWIDTH_IN];
  assign unused_low_bits = ^bus.data_in;

  // Next-state and per-cycle action decode; every action is qualified by EN.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    wr_en      = 1'b0;
    rd_issue   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en && bus.trgg_start_calc) begin
          load       = 1'b1;
          state_next = bus.rnw ? WRITE : READ;
        end
      end
      WRITE: begin
        if (bus.en && bus.din_valid) begin
          wr_en = 1'b1;
          if (cnt == CNT_ONE) begin
            state_next = IDLE;
            finish     = 1'b1;
          end
        end
      end
      READ: begin
        if (bus.en) begin
          rd_issue = 1'b1;
          if (cnt == CNT_ONE) state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The last word sits in the output register once the pipe is empty.
        if (bus.en && out_valid && !(|pipe_valid)) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, burst address pointer, remaining-word counter and DONE flag.
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        ptr <= bus.adr;
        cnt <= (bus.len == '0) ? FULL_LEN : {1'b0, bus.len};
      end else if (wr_en || rd_issue) begin
        ptr <= ptr + BITWIDTH_ADR'(1);
        cnt <= cnt - CNT_ONE;
      end
      if (bus.en) done_q <= finish;
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[ptr] <= payload;
  end

  // Read pipeline: RAM read into stage 0, shift through, land in the output register.
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      pipe_valid <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_data[i] <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (bus.en) begin
      pipe_valid[0] <= rd_issue;
      if (rd_issue) pipe_data[0] <= mem[ptr];
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
      out_valid <= pipe_valid[RD_LATENCY-1];
      if (pipe_valid[RD_LATENCY-1]) out_data <= pipe_data[RD_LATENCY-1];
    end
  end

  // Output drive: MSB-aligned read data, EN-qualified strobes, constant header.
  always_comb begin
    bus.data_out = '0;
    bus.data_out[BITWIDTH_SYS-1 -: BITWIDTH_IN] = out_data;
    bus.dout_valid = out_valid & bus.en;
    bus.done       = done_q & bus.en;
    bus.rdy        = (state == IDLE);
    bus.data_head  = BITWIDTH_HEAD'({4'd3, HEAD_LAT, HEAD_LEN, HEAD_ADR, HEAD_IN, HEAD_IN});
  end

endmodule

// File: doc/skeleton_ram_burst.md
# skeleton_ram_burst

On-device test skeleton for RAM structures, successor to the single-access RAM skeleton. It adds length-programmable burst writes and reads with auto-incrementing, wrapping addresses. It adds a configurable read-pipeline latency and valid/ready/done handshakes. It sits between the device data bus (BITWIDTH_SYS wide, MSB-aligned payload) and an internal single-port synchronous RAM of 2**BITWIDTH_ADR words × BITWIDTH_IN bits.

## Interface
- BITWIDTH_IN, 12: RAM word width (≤ BITWIDTH_SYS, ≤ 31).
- BITWIDTH_SYS, 16: device data-bus width.
- BITWIDTH_ADR, 6: address width; depth = 2**BITWIDTH_ADR.
- BITWIDTH_LEN, 6: burst-length field width.
- RD_LATENCY, 1: read latency in cycles, 1..15, from address issue to DOUT_VALID.
- BITWIDTH_HEAD, 30: metadata width.
- CLK_SYS  in  1  system clock; all logic on the rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- EN  in  1  global enable; low freezes all state, including the read pipeline.
- TRGG_START_CALC  in  1  start pulse; sampled only in IDLE with EN=1.
- RnW  in  1  1 = write burst, 0 = read burst; sampled at start.
- ADR  in  BITWIDTH_ADR  burst start address; sampled at start.
- LEN  in  BITWIDTH_LEN  word count; 0 means 2**BITWIDTH_LEN; sampled at start.
- DATA_IN  in  BITWIDTH_SYS  write data; payload = bits [BITWIDTH_SYS-1 -: BITWIDTH_IN].
- DIN_VALID  in  1  write-data qualifier.
- DATA_OUT  out  BITWIDTH_SYS  read data; payload MSB-aligned, low bits zero.
- DOUT_VALID  out  1  read-data qualifier, one cycle per word.
- DATA_HEAD  out  BITWIDTH_HEAD  constant {4'd3, RD_LATENCY[3:0], BITWIDTH_LEN[5:0], BITWIDTH_ADR[5:0], BITWIDTH_IN[4:0], BITWIDTH_IN[4:0]}.
- RDY  out  1  high in IDLE only.
- DONE  out  1  one-cycle pulse when a burst completes.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE → WRITE or READ when EN & TRGG_START_CALC. On that edge, latch ptr←ADR, cnt←LEN (0 → 2**BITWIDTH_LEN), mode←RnW.
- WRITE: each EN & DIN_VALID cycle performs mem[ptr]←payload, ptr←ptr+1 (mod depth), cnt←cnt−1. A DIN_VALID=0 cycle stalls without writing.
  - After the write with cnt=1, go to IDLE and pulse DONE.
- READ: each EN cycle issues a read of mem[ptr], ptr←ptr+1 (mod depth), cnt←cnt−1. After the issue with cnt=1, go to DRAIN.
- DRAIN: wait until the last issued word leaves the pipeline, then go to IDLE and pulse DONE.
- Read pipeline: a RD_LATENCY-deep shift of {valid, data}. It advances only when EN=1. DATA_OUT holds its last value when DOUT_VALID=0.
- Address wrap: ptr wraps from 2**BITWIDTH_ADR−1 to 0 mid-burst. LEN may exceed depth; addresses are then revisited.
- TRGG_START_CALC outside IDLE is ignored, with no queuing.
- EN=0 in any state: no memory access, no state, counter or pipeline change, DONE=0, DOUT_VALID held at 0.
- Reset (asserted at any time, including mid-burst): FSM=IDLE, ptr=0, cnt=0, pipeline cleared, DATA_OUT=0, DOUT_VALID=0, DONE=0, RDY=1. Memory contents are not cleared.

## Timing
- Start sampled at edge 0. RDY falls after edge 0.
- Write: the first DATA_IN is sampled at edge 1. With DIN_VALID held high, an N-word write ends at edge N. DONE and RDY are high after edge N.
- Read: the address is issued at edges 1..N. Word k has DOUT_VALID high after edge k+RD_LATENCY−1+1, i.e. in cycle k+RD_LATENCY.
  - DONE is high in the cycle after the last DOUT_VALID, together with RDY=1. It is never coincident with DOUT_VALID.
- Throughput: 1 word/cycle in both directions with no gaps.
- Back-to-back: a start may be sampled in the same cycle that DONE is high. The next burst begins immediately.

## Test plan
- Reset mid-read (RD_LATENCY=3, LEN=10, RSTN low at word 4): all outputs return to reset values immediately, and RDY=1. A following 1-word read at addr 0 returns the previously written data.
- Write ADR=0, LEN=4, data 0x1230/0x4560/0x7890/0xABC0, DIN_VALID toggled 1,0,1,1,0,1: exactly 4 writes, DONE on the 4th. Read-back ADR=0, LEN=4, RD_LATENCY=1 returns the same words with low 4 bits 0 and 4 consecutive DOUT_VALID cycles.
- Wrap: write ADR=62, LEN=4 (BITWIDTH_ADR=6) then read ADR=62, LEN=4: data order preserved across addresses 62, 63, 0, 1.
- LEN=0: the burst runs 64 words. DONE appears exactly once, after the 64th.
- RD_LATENCY=4, read LEN=3, EN low for 2 cycles during DRAIN: DOUT_VALID sequence is shifted by exactly 2 cycles, and DONE follows the last valid by 1 cycle.
- Start pulse while busy: ignored, and the burst count is unchanged. Start in the DONE cycle begins the new burst with RDY low next cycle. DATA_HEAD equals {4'd3,4'd1,6'd6,6'd6,5'd12,5'd12} for default parameters.
